// File: rtl/rgb_contrast_pipe.sv
// rgb_contrast_pipe: 3-stage mid-point-centred contrast gain with rounding and saturation.
// Define CONTRAST_CLIP_STATS_EN to build the per-frame clipped-sample counter.
module rgb_contrast_pipe #(
  parameter int DATA_W     = 8,
  parameter int CHANNELS   = 3,
  parameter int LEVEL_W    = 4,
  parameter int STEP_SHIFT = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic [LEVEL_W-1:0]           contrast_level,
  input  logic                         bypass,
  output logic                         out_valid,
  output logic                         out_sof,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic [15:0]                  clip_count
);
  localparam int GW  = DATA_W + 2;
  localparam int DW  = DATA_W + 1;
  localparam int PW  = DW + GW + 1;
  localparam int PXW = CHANNELS * DATA_W;
  localparam logic [GW-1:0] UNITY = GW'(2**DATA_W);
  localparam logic [GW-1:0] OFS   = GW'(2**(LEVEL_W-1+STEP_SHIFT));
  localparam logic [DW-1:0] MID_D = DW'(2**(DATA_W-1));
  localparam logic signed [PW-1:0] HALF = PW'(2**(DATA_W-1));
  logic [GW-1:0] gain_q, gain_d, gain_lvl, g1_q;
  logic byp_q, byp_d, b1_q, b2_q;
  logic [2:0] v_q, sof_q;
  logic [PXW-1:0] x1_q, x2_q, out_q, out_d;
  logic signed [DW-1:0] d1_q [CHANNELS];
  logic signed [DW-1:0] d1_d [CHANNELS];
  logic signed [PW-1:0] p2_q [CHANNELS];
  logic signed [PW-1:0] p2_d [CHANNELS];
  logic signed [PW-1:0] y [CHANNELS];
  logic [CHANNELS-1:0] neg, hi;
  // An accepted SOF pixel already uses the settings presented with it.
  always_comb begin
    gain_lvl = UNITY + (GW'(contrast_level) << STEP_SHIFT) - OFS;
    gain_d   = (in_valid && in_sof) ? gain_lvl : gain_q;
    byp_d    = (in_valid && in_sof) ? bypass : byp_q;
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign d1_d[c] = {1'b0, in_data[c*DATA_W +: DATA_W]} - MID_D;
    assign p2_d[c] = PW'(d1_q[c]) * PW'($signed({1'b0, g1_q}));
    assign y[c]    = ((p2_q[c] + HALF) >>> DATA_W) + HALF;
    assign neg[c]  = y[c][PW-1];
    assign hi[c]   = !y[c][PW-1] && (y[c][PW-2:DATA_W] != '0);
    assign out_d[c*DATA_W +: DATA_W] = b2_q ? x2_q[c*DATA_W +: DATA_W] :
                                       neg[c] ? '0 : hi[c] ? '1 : y[c][DATA_W-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gain_q <= UNITY;
      byp_q  <= 1'b0;
      v_q    <= '0;
      sof_q  <= '0;
      g1_q   <= UNITY;
      b1_q   <= 1'b0;
      b2_q   <= 1'b0;
      x1_q   <= '0;
      x2_q   <= '0;
      out_q  <= '0;
      d1_q   <= '{default: '0};
      p2_q   <= '{default: '0};
    end else begin
      gain_q <= gain_d;
      byp_q  <= byp_d;
      v_q    <= {v_q[1:0], in_valid};
      sof_q  <= {sof_q[1:0], in_valid & in_sof};
      g1_q   <= gain_d;
      b1_q   <= byp_d;
      b2_q   <= b1_q;
      x1_q   <= in_data;
      x2_q   <= x1_q;
      d1_q   <= d1_d;
      p2_q   <= p2_d;
      if (v_q[1]) out_q <= out_d;
    end
  end
  assign out_valid = v_q[2];
  assign out_sof   = sof_q[2];
  assign out_data  = out_q;
`ifdef CONTRAST_CLIP_STATS_EN
  logic [CHANNELS-1:0] clip;
  logic [16:0] sum;
  logic [15:0] acc_q, cc_q;
  assign clip = (neg | hi) & {CHANNELS{~b2_q}};
  assign sum  = {1'b0, acc_q} + 17'($countones(clip));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cc_q  <= '0;
    end else if (v_q[1]) begin
      if (sof_q[1]) begin
        cc_q  <= acc_q;
        acc_q <= 16'($countones(clip));
      end else acc_q <= sum[16] ? '1 : sum[15:0];
    end
  end
  assign clip_count = cc_q;
`else
  assign clip_count = '0;
`endif
endmodule

// File: tb/tb_rgb_contrast_pipe.sv
// tb_rgb_contrast_pipe: directed and random pixel streams checked against an arithmetic contrast model.
module tb_rgb_contrast_pipe;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sof = 1'b0, bypass = 1'b0;
  logic [23:0] in_data = '0;
  logic [3:0] contrast_level = 4'd8;
  logic out_valid, out_sof;
  logic [23:0] out_data;
  logic [15:0] clip_count;
  int n = 0, errs = 0;
  typedef struct {bit v; bit sof; logic [23:0] d; int nc;} exp_t;
  exp_t pipe [3];
  int m_lvl = 8, m_acc = 0, m_cc = 0;
  bit m_byp = 1'b0;
  logic [23:0] last = '0;
  always #5 clk = ~clk;
  rgb_contrast_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .contrast_level(contrast_level), .bypass(bypass), .out_valid(out_valid),
    .out_sof(out_sof), .out_data(out_data), .clip_count(clip_count)
  );
  function automatic int fdiv(int a, int b);
    return a >= 0 ? a / b : -((-a + b - 1) / b);
  endfunction
  function automatic logic [23:0] px(int a, int b, int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction
  function automatic void model(input logic [23:0] p, input int lvl, input bit byp,
                                output logic [23:0] yo, output int nc);
    int gain, x, r;
    nc = 0;
    yo = '0;
    gain = 256 + (lvl - 8) * 32;
    for (int c = 0; c < 3; c++) begin
      x = int'(p[c*8 +: 8]);
      r = byp ? x : fdiv((x - 128) * gain + 128, 256) + 128;
      if (r < 0) begin r = 0; nc++; end
      else if (r > 255) begin r = 255; nc++; end
      yo[c*8 +: 8] = 8'(r);
    end
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic reset_model();
    for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 1'b0, 24'h0, 0};
    m_lvl = 8;
    m_byp = 1'b0;
    last = '0;
    m_acc = 0;
    m_cc = 0;
  endtask
  task automatic cyc(bit v, bit s, logic [23:0] d, int lvl, bit byp);
    exp_t e;
    logic [23:0] yv;
    int nc;
    in_valid = v;
    in_sof = s;
    in_data = d;
    contrast_level = 4'(lvl);
    bypass = byp;
    if (v && s) begin m_lvl = lvl; m_byp = byp; end
    model(d, m_lvl, m_byp, yv, nc);
    e = '{v, v && s, yv, nc};
    @(negedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
    if (pipe[2].v) begin
      last = pipe[2].d;
`ifdef CONTRAST_CLIP_STATS_EN
      if (pipe[2].sof) begin m_cc = m_acc; m_acc = pipe[2].nc; end
      else m_acc = (m_acc + pipe[2].nc > 65535) ? 65535 : m_acc + pipe[2].nc;
`endif
    end
    chk("out_valid", 32'(out_valid), 32'(pipe[2].v));
    chk("out_sof", 32'(out_sof), 32'(pipe[2].sof));
    chk("out_data", 32'(out_data), 32'(last));
    chk("clip_count", 32'(clip_count), 32'(m_cc));
  endtask
  task automatic idle(int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 24'h0, 8, 1'b0);
  endtask
  initial begin
    reset_model();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_sof", 32'(out_sof), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_clip", 32'(clip_count), 32'h0);
    rst = 1'b0;
    cyc(1, 1, px(200, 28, 128), 8, 0);
    idle(3);
    cyc(1, 1, px(200, 100, 28), 12, 0);
    cyc(1, 0, px(10, 250, 128), 12, 0);
    cyc(1, 1, px(200, 128, 56), 15, 0);
    cyc(1, 1, px(17, 99, 240), 0, 0);
    idle(3);
    cyc(1, 1, px(40, 90, 220), 8, 0);
    cyc(1, 0, px(200, 56, 3), 15, 0);
    cyc(1, 0, px(250, 1, 130), 15, 0);
    cyc(1, 1, px(200, 56, 3), 15, 0);
    cyc(1, 1, px(250, 3, 77), 15, 1);
    cyc(0, 0, px(0, 0, 0), 15, 0);
    cyc(1, 0, px(255, 0, 128), 15, 0);
    cyc(1, 1, px(10, 20, 30), 3, 0);
    cyc(0, 1, px(5, 5, 5), 15, 1);
    idle(3);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 24'($urandom),
          int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
    cyc(1, 1, px(1, 2, 3), 13, 0);
    idle(3);
    cyc(1, 1, px(220, 30, 140), 14, 0);
    cyc(1, 0, px(230, 20, 100), 14, 0);
    cyc(1, 0, px(240, 10, 160), 14, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'h0);
    chk("rst_mid_data", 32'(out_data), 32'h0);
    reset_model();
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_valid", 32'(out_valid), 32'h0);
    end
    rst = 1'b0;
    idle(3);
    cyc(1, 0, px(200, 28, 128), 15, 0);
    cyc(1, 0, px(250, 3, 77), 0, 1);
    cyc(1, 0, px(0, 255, 129), 12, 0);
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
